// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default frame constants
// used by the baud generator, transmitter and receiver.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous UART rx line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame_decoder.sv
// UART receive frame decoder: start detection, centre sampling, stop/parity checks and a
// valid/ready output with overrun reporting. Parity support is built with UART_RX_PARITY_EN.
module uart_rx_frame_decoder
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TCNT_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

    logic rxs;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (rx),
        .dout(rxs)
    );

    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_done;
    logic                 frame_perr;

`ifdef UART_RX_PARITY_EN
    // Parity outcome is computed in PARITY and held until the stop bit publishes it.
    logic perr_q, perr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign frame_perr = perr_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign frame_perr        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
`endif

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end

            START: begin
                if (sample_tick) begin
                    if (tcnt_q == TCNT_HALF) begin
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (sample_tick) begin
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d  = '0;
                        // Shift in at the MSB so the first (LSB) bit lands in bit 0.
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_tick) begin
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d  = '0;
                        perr_d  = (^shreg_q) ^ rxs ^ parity_odd;
                        state_d = STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (sample_tick) begin
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d     = '0;
                        frame_done = 1'b1;
                        // A low stop bit may be a break; wait for the line to recover.
                        state_d    = rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;

        if (frame_done) begin
            rx_data_d    = shreg_q;
            frame_err_d  = ~rxs;
            parity_err_d = frame_perr;
            rx_valid_d   = 1'b1;
            overrun_d    = rx_valid_q & ~rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
